// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared state encoding, port ids and op constants for mem_arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam logic       PORT_I     = 1'b0;
  localparam logic       PORT_D     = 1'b1;
  localparam logic [2:0] MEMOP_WORD = 3'b010;

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// rtl/mem_arbiter_arb_pick.sv - winner select between fetch and data ports
// MEM_ARB_RR_EN selects round-robin on contention; otherwise D beats I.
module arb_pick
  import mem_arb_pkg::*;
(
  input  logic i_req,
  input  logic d_req,
`ifdef MEM_ARB_RR_EN
  input  logic rr_last,
`endif
  output logic grant_valid,
  output logic grant
);

  always_comb begin
    grant_valid = i_req | d_req;
    grant       = PORT_I;
`ifdef MEM_ARB_RR_EN
    if (i_req && d_req) begin
      grant = ~rr_last;
    end else if (d_req) begin
      grant = PORT_D;
    end
`else
    if (d_req) begin
      grant = PORT_D;
    end
`endif
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port memory arbiter for CPU fetch (I) and load/store (D) ports
// MEM_ARB_RR_EN enables round-robin arbitration on contention.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_ack,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  input  logic [2:0]    d_op,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [2:0]    mem_op,
  input  logic [DW-1:0] mem_rdata
);

  state_e        state_q, state_d;
  logic          owner_q, owner_d;
  logic          mem_en_q, mem_en_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [2:0]    mem_op_q, mem_op_d;
  logic          i_ack_q, i_ack_d;
  logic          d_ack_q, d_ack_d;
  logic [DW-1:0] i_rdata_q, i_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          grant_valid;
  logic          grant;

`ifdef MEM_ARB_RR_EN
  logic          rr_last_q, rr_last_d;
`endif

  arb_pick u_arb_pick (
    .i_req       (i_req),
    .d_req       (d_req),
`ifdef MEM_ARB_RR_EN
    .rr_last     (rr_last_q),
`endif
    .grant_valid (grant_valid),
    .grant       (grant)
  );

  // mem_* registers double as the latched request fields for the access in flight
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    mem_en_d    = 1'b0;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_op_d    = mem_op_q;
    i_ack_d     = 1'b0;
    d_ack_d     = 1'b0;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
`ifdef MEM_ARB_RR_EN
    rr_last_d   = rr_last_q;
`endif
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          owner_d  = grant;
          mem_en_d = 1'b1;
          state_d  = ACCESS;
`ifdef MEM_ARB_RR_EN
          rr_last_d = grant;
`endif
          if (grant == PORT_D) begin
            mem_we_d    = d_we;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
            mem_op_d    = d_op;
          end else begin
            mem_we_d    = 1'b0;
            mem_addr_d  = i_addr;
            mem_wdata_d = '0;
            mem_op_d    = MEMOP_WORD;
          end
        end
      end
      ACCESS: begin
        state_d = RESP;
        if (owner_q == PORT_D) begin
          d_ack_d = 1'b1;
        end else begin
          i_ack_d = 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
        if (owner_q == PORT_I) begin
          i_rdata_d = mem_rdata;
        end else if (!mem_we_q) begin
          d_rdata_d = mem_rdata;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= PORT_I;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_op_q    <= '0;
      i_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
`ifdef MEM_ARB_RR_EN
      rr_last_q   <= PORT_D;
`endif
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_op_q    <= mem_op_d;
      i_ack_q     <= i_ack_d;
      d_ack_q     <= d_ack_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
`ifdef MEM_ARB_RR_EN
      rr_last_q   <= rr_last_d;
`endif
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_op    = mem_op_q;
  assign i_ack     = i_ack_q;
  assign d_ack     = d_ack_q;

  // Memory data arrives in the ack cycle, so forward it then and hold the captured copy after
  assign i_rdata = i_ack_q ? mem_rdata : i_rdata_q;
  assign d_rdata = (d_ack_q && !mem_we_q) ? mem_rdata : d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter with a synchronous memory model
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [2:0]  d_op = '0;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [2:0]  mem_op;
  logic [31:0] mem_rdata = '0;

  logic [31:0] mem_model [0:255];

  int n_cmp = 0;
  int n_bad = 0;

  mem_arbiter #(.AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_op(d_op),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_op(mem_op), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem_model[mem_addr[9:2]] <= mem_wdata;
      else        mem_rdata <= mem_model[mem_addr[9:2]];
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  int d_ack_cyc;
  int i_ack_cyc;
  int n_acks;
  logic order [0:7];
  logic [0:3] exp_order;

  initial begin
    for (int a = 0; a < 256; a++) mem_model[a] = '0;
    mem_model[0] = 32'h0000_0013;
    mem_model[1] = 32'h0050_0093;

    repeat (2) @(negedge clk);
    check("rst_i_ack", i_ack, 0);
    check("rst_d_ack", d_ack, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_op", mem_op, 0);
    check("rst_i_rdata", i_rdata, 0);
    check("rst_d_rdata", d_rdata, 0);
    rst = 1'b0;
    @(negedge clk);

    // fetch-only read
    i_req = 1'b1; i_addr = 32'h0;
    @(negedge clk);
    check("f_mem_en", mem_en, 1);
    check("f_mem_addr", mem_addr, 32'h0);
    check("f_mem_op", mem_op, 3'b010);
    check("f_mem_we", mem_we, 0);
    check("f_early_ack", i_ack, 0);
    @(negedge clk);
    check("f_i_ack", i_ack, 1);
    check("f_i_rdata", i_rdata, 32'h13);
    check("f_d_ack", d_ack, 0);
    check("f_mem_en_off", mem_en, 0);
    i_req = 1'b0;
    @(negedge clk);
    check("f_ack_pulse", i_ack, 0);
    check("f_rdata_hold", i_rdata, 32'h13);

    // store
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF; d_op = 3'b010;
    @(negedge clk);
    check("s_mem_en", mem_en, 1);
    check("s_mem_we", mem_we, 1);
    check("s_mem_addr", mem_addr, 32'h100);
    check("s_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    @(negedge clk);
    check("s_d_ack", d_ack, 1);
    check("s_d_rdata", d_rdata, 0);
    check("s_i_ack", i_ack, 0);
    d_req = 1'b0;
    @(negedge clk);

    // load with mid-flight address change and non-word op
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100; d_op = 3'b101;
    @(negedge clk);
    check("l_mem_en", mem_en, 1);
    check("l_mem_we", mem_we, 0);
    check("l_mem_op", mem_op, 3'b101);
    d_addr = 32'h200;
    @(negedge clk);
    check("l_mem_addr_held", mem_addr, 32'h100);
    check("l_d_ack", d_ack, 1);
    check("l_d_rdata", d_rdata, 32'hDEAD_BEEF);
    check("l_i_rdata_hold", i_rdata, 32'h13);
    d_req = 1'b0; d_addr = 32'h100; d_op = 3'b010;
    @(negedge clk);
    check("l_rdata_hold", d_rdata, 32'hDEAD_BEEF);

    // contention, each port drops req after its ack
    d_ack_cyc = -1; i_ack_cyc = -1;
    i_req = 1'b1; i_addr = 32'h0; d_req = 1'b1; d_we = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (d_ack) begin
        d_ack_cyc = k;
        check("c_d_rdata", d_rdata, 32'hDEAD_BEEF);
        d_req = 1'b0;
      end
      if (i_ack) begin
        i_ack_cyc = k;
        check("c_i_rdata", i_rdata, 32'h13);
        i_req = 1'b0;
      end
    end
`ifdef MEM_ARB_RR_EN
    check("c_i_ack_cycle", i_ack_cyc, 2);
    check("c_d_ack_cycle", d_ack_cyc, 5);
    exp_order = 4'b0101;
`else
    check("c_d_ack_cycle", d_ack_cyc, 2);
    check("c_i_ack_cycle", i_ack_cyc, 5);
    exp_order = 4'b1111;
`endif

    // sustained contention: both held for four transactions
    n_acks = 0;
    i_req = 1'b1; d_req = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (d_ack && n_acks < 8) begin order[n_acks] = PORT_D; n_acks++; end
      if (i_ack && n_acks < 8) begin order[n_acks] = PORT_I; n_acks++; end
    end
    i_req = 1'b0; d_req = 1'b0;
    check("sc_n_acks", n_acks, 4);
    for (int g = 0; g < 4; g++) check($sformatf("sc_grant%0d", g), order[g], exp_order[g]);
    repeat (2) @(negedge clk);

    // reset during ACCESS
    i_req = 1'b1; i_addr = 32'h0;
    @(negedge clk);
    check("r_in_access", mem_en, 1);
    rst = 1'b1; i_req = 1'b0;
    @(negedge clk);
    check("r_mem_en", mem_en, 0);
    check("r_i_ack", i_ack, 0);
    check("r_d_ack", d_ack, 0);
    check("r_state", dut.state_q, IDLE);
    check("r_i_rdata", i_rdata, 0);
    check("r_d_rdata", d_rdata, 0);
    rst = 1'b0;
    @(negedge clk);
    check("r_no_late_ack", i_ack, 0);

    // request after reset completes normally
    i_req = 1'b1; i_addr = 32'h4;
    @(negedge clk);
    check("p_mem_addr", mem_addr, 32'h4);
    @(negedge clk);
    check("p_i_ack", i_ack, 1);
    check("p_i_rdata", i_rdata, 32'h0050_0093);
    i_req = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
